// File: rtl/pipe_reg_if.sv
// Valid/ready/data handshake bundle used on both faces of pipe_reg.
// The master drives valid and data; the slave answers with ready.
interface pipe_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_reg.sv
// Elastic pipeline of DEPTH valid/ready register stages with synchronous flush.
// Bubbles compact toward the output; the ready chain is purely combinational.
module pipe_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    pipe_reg_if.slave                  up,
    pipe_reg_if.master                 dn,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned OccW = $clog2(DEPTH + 1);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $fatal(1, "pipe_reg: WIDTH must be in 1..64");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $fatal(1, "pipe_reg: DEPTH must be in 1..8");
    end

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0] stage_ready;
    logic [OccW-1:0]  occ_q, occ_d;
    logic             in_fire, out_fire;

    // Walk from the output back to stage 0 so each stage sees its successor's ready.
    always_comb begin
        logic succ_ready;
        succ_ready  = dn.ready;
        stage_ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            succ_ready     = !valid_q[i] || succ_ready;
            stage_ready[i] = succ_ready;
        end
    end

    always_comb begin
        src_valid[0] = up.valid;
        src_data[0]  = up.data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    assign up.ready  = stage_ready[0] && !flush;
    assign in_fire   = up.valid && up.ready;
    assign out_fire  = valid_q[DEPTH-1] && dn.ready;
    assign dn.valid  = valid_q[DEPTH-1];
    assign dn.data   = data_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        occ_d   = occ_q;
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VALUE;
            end
            occ_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    valid_d[i] = src_valid[i];
                    // Data only moves with a real item so a drained stage keeps its last value.
                    if (src_valid[i]) begin
                        data_d[i] = src_data[i];
                    end
                end
            end
            case ({in_fire, out_fire})
                2'b10:   occ_d = occ_q + OccW'(1);
                2'b01:   occ_d = occ_q - OccW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
            occ_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg: vector table on a 3-deep instance, plus hand
// sequences for flush (2-deep), alternating backpressure (1-deep) and async reset.
module tb_pipe_reg;
    logic clk;
    logic rst;
    logic flush_a, flush_b, flush_c;
    logic [1:0] occ_a;
    logic [1:0] occ_b;
    logic [0:0] occ_c;

    int checks = 0;
    int errors = 0;

    pipe_reg_if #(.WIDTH(32)) a_up ();
    pipe_reg_if #(.WIDTH(32)) a_dn ();
    pipe_reg_if #(.WIDTH(16)) b_up ();
    pipe_reg_if #(.WIDTH(16)) b_dn ();
    pipe_reg_if #(.WIDTH(8))  c_up ();
    pipe_reg_if #(.WIDTH(8))  c_dn ();

    pipe_reg #(.WIDTH(32), .DEPTH(3), .RESET_VALUE(32'h0)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush_a), .up(a_up), .dn(a_dn), .occupancy(occ_a)
    );
    pipe_reg #(.WIDTH(16), .DEPTH(2), .RESET_VALUE(16'hDEAD)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush_b), .up(b_up), .dn(b_dn), .occupancy(occ_b)
    );
    pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h00)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush_c), .up(c_up), .dn(c_dn), .occupancy(occ_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q [$];
    logic [7:0] next_d;
    logic       exp_ir;

    initial begin
        // iv, data, out_ready, flush | in_ready, out_valid, out_data, occupancy
        vecs[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0};
        vecs[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd1};
        vecs[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd2};
        vecs[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 2'd3};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 2'd3};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3, 2'd2};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 2'd1};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 2'd0};
        vecs[8]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 2'd0};
        vecs[9]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 2'd1};
        vecs[10] = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 2'd2};
        vecs[11] = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA, 2'd3};
        vecs[12] = '{1'b1, 32'hD, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA, 2'd3};
        vecs[13] = '{1'b1, 32'hE, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB, 2'd3};
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 2'd3};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hD, 2'd2};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hD, 2'd2};
        vecs[17] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE, 2'd1};
        vecs[18] = '{1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b0, 32'hE, 2'd0};
        vecs[19] = '{1'b1, 32'h6, 1'b1, 1'b1, 1'b0, 1'b0, 32'hE, 2'd1};
        vecs[20] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0};

        rst = 1'b0;
        flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
        a_up.valid = 1'b0; a_up.data = '0; a_dn.ready = 1'b0;
        b_up.valid = 1'b0; b_up.data = '0; b_dn.ready = 1'b0;
        c_up.valid = 1'b0; c_up.data = '0; c_dn.ready = 1'b0;

        // Reset is applied before any clock edge, so these values come from the async path.
        #1 rst = 1'b1;
        #2;
        chk("rst_d3_out_valid", 64'(a_dn.valid), 64'h0);
        chk("rst_d3_out_data", 64'(a_dn.data), 64'h0);
        chk("rst_d3_occupancy", 64'(occ_a), 64'h0);
        chk("rst_d3_in_ready", 64'(a_up.ready), 64'h1);
        chk("rst_d2_out_data", 64'(b_dn.data), 64'hDEAD);
        chk("rst_d2_out_valid", 64'(b_dn.valid), 64'h0);
        chk("rst_d1_out_valid", 64'(c_dn.valid), 64'h0);
        chk("rst_d1_occupancy", 64'(occ_c), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        step();

        for (int i = 0; i < 21; i++) begin
            a_up.valid = vecs[i].iv;
            a_up.data  = vecs[i].d;
            a_dn.ready = vecs[i].ordy;
            flush_a    = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(a_up.ready), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d_out_valid", i), 64'(a_dn.valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_data", i), 64'(a_dn.data), 64'(vecs[i].e_od));
            chk($sformatf("v%0d_occupancy", i), 64'(occ_a), 64'(vecs[i].e_occ));
            step();
        end
        a_up.valid = 1'b0;
        a_dn.ready = 1'b0;
        flush_a    = 1'b0;

        // Flush on a 2-deep stage with two items: oldest is consumed, rest discarded.
        b_dn.ready = 1'b0;
        b_up.valid = 1'b1; b_up.data = 16'h0011;
        step();
        b_up.data = 16'h0022;
        step();
        b_up.valid = 1'b0;
        #1;
        chk("d2_full_out_valid", 64'(b_dn.valid), 64'h1);
        chk("d2_full_out_data", 64'(b_dn.data), 64'h0011);
        chk("d2_full_occupancy", 64'(occ_b), 64'h2);
        chk("d2_full_in_ready", 64'(b_up.ready), 64'h0);
        flush_b = 1'b1; b_dn.ready = 1'b1; b_up.valid = 1'b1; b_up.data = 16'h0033;
        #1;
        chk("d2_flush_in_ready", 64'(b_up.ready), 64'h0);
        chk("d2_flush_out_valid", 64'(b_dn.valid), 64'h1);
        chk("d2_flush_out_data", 64'(b_dn.data), 64'h0011);
        step();
        flush_b = 1'b0; b_dn.ready = 1'b0; b_up.valid = 1'b0;
        #1;
        chk("d2_post_out_valid", 64'(b_dn.valid), 64'h0);
        chk("d2_post_out_data", 64'(b_dn.data), 64'hDEAD);
        chk("d2_post_occupancy", 64'(occ_b), 64'h0);
        chk("d2_post_in_ready", 64'(b_up.ready), 64'h1);
        step();

        // 1-deep stage, continuous input, alternating downstream ready.
        next_d = 8'h40;
        c_up.valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            c_dn.ready = (i % 2 == 0);
            c_up.data  = next_d;
            #1;
            exp_ir = (q.size() == 0) || c_dn.ready;
            chk("d1_in_ready", 64'(c_up.ready), 64'(exp_ir));
            chk("d1_out_valid", 64'(c_dn.valid), 64'(q.size() != 0));
            chk("d1_occupancy", 64'(occ_c), 64'(q.size()));
            if (q.size() != 0 && c_dn.ready) begin
                chk("d1_out_data", 64'(c_dn.data), 64'(q[0]));
                void'(q.pop_front());
            end
            if (exp_ir) begin
                q.push_back(next_d);
                next_d++;
            end
            step();
        end
        c_up.valid = 1'b0;
        c_dn.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (q.size() != 0) begin
                chk("d1_drain_out_valid", 64'(c_dn.valid), 64'h1);
                chk("d1_drain_out_data", 64'(c_dn.data), 64'(q[0]));
                void'(q.pop_front());
            end
            step();
        end
        chk("d1_drained", 64'(c_dn.valid), 64'h0);
        c_dn.ready = 1'b0;

        // Mid-cycle async reset on the 3-deep stage while it holds three items.
        a_dn.ready = 1'b1;
        a_up.valid = 1'b1;
        a_up.data = 32'h7; step();
        a_up.data = 32'h8; step();
        a_up.data = 32'h9; step();
        a_up.valid = 1'b0;
        a_dn.ready = 1'b0;
        #1;
        chk("mid_pre_out_valid", 64'(a_dn.valid), 64'h1);
        chk("mid_pre_out_data", 64'(a_dn.data), 64'h7);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(a_dn.valid), 64'h0);
        chk("mid_rst_out_data", 64'(a_dn.data), 64'h0);
        chk("mid_rst_occupancy", 64'(occ_a), 64'h0);
        chk("mid_rst_in_ready", 64'(a_up.ready), 64'h1);
        #2 rst = 1'b0;
        step();
        a_dn.ready = 1'b1;
        a_up.valid = 1'b1;
        a_up.data  = 32'h11;
        step();
        a_up.valid = 1'b0;
        #1;
        chk("post_rst_c1_out_valid", 64'(a_dn.valid), 64'h0);
        step();
        chk("post_rst_c2_out_valid", 64'(a_dn.valid), 64'h0);
        step();
        chk("post_rst_c3_out_valid", 64'(a_dn.valid), 64'h1);
        chk("post_rst_c3_out_data", 64'(a_dn.data), 64'h11);
        chk("post_rst_c3_occupancy", 64'(occ_a), 64'h1);
        step();
        chk("post_rst_empty", 64'(a_dn.valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
